// File: rtl/mul_sequencer.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier with HI/LO commit and MFHI/MFLO reads.
// Optional MUL_EARLY_EXIT_EN ends the iteration loop once no multiplier bits remain.
module mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             bad_op
);

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] mcnd_q, mcnd_d;
  logic [WIDTH-1:0]   mpr_q, mpr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               out_valid_q, out_valid_d;
  logic               bad_op_q, bad_op_d;
  logic               accept;
  logic               last_iter;

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

`ifdef MUL_EARLY_EXIT_EN
  // Stop as soon as the remaining multiplier bits are all zero; further adds would be no-ops.
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || ((mpr_q >> 1) == '0);
`else
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    product_d   = product_q;
    mcnd_d      = mcnd_q;
    mpr_d       = mpr_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dout_d      = dout_q;
    out_valid_d = 1'b0;
    bad_op_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (Signal)
            FUNCT_MULTU: begin
              product_d = '0;
              mcnd_d    = {{WIDTH{1'b0}}, dataA};
              mpr_d     = dataB;
              cnt_d     = '0;
              state_d   = S_RUN;
            end
            FUNCT_MFHI: begin
              dout_d      = hi_q;
              out_valid_d = 1'b1;
            end
            FUNCT_MFLO: begin
              dout_d      = lo_q;
              out_valid_d = 1'b1;
            end
            default: bad_op_d = 1'b1;
          endcase
        end
      end
      S_RUN: begin
        if (mpr_q[0]) product_d = product_q + mcnd_q;
        mcnd_d = mcnd_q << 1;
        mpr_d  = mpr_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        {hi_d, lo_d} = product_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      product_q   <= '0;
      mcnd_q      <= '0;
      mpr_q       <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      bad_op_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      product_q   <= product_d;
      mcnd_q      <= mcnd_d;
      mpr_q       <= mpr_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      bad_op_q    <= bad_op_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dataOut   = dout_q;
  assign out_valid = out_valid_q;
  assign bad_op    = bad_op_q;

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Controller and shift-add datapath for the unsigned 32x32 multiply used by the ALU/multiply stage.
- Accepts one funct-coded request per handshake.
- Sequences one add/shift iteration per clock.
- Commits the 64-bit product into the architectural HI/LO registers.
- Serves MFHI/MFLO reads.
- Stalls new requests while a multiply is in flight.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH; iteration count equals WIDTH
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present this cycle
req_ready  output  1  block can accept a request
Signal  input  6  funct code: 6'b011001 MULTU, 6'b010000 MFHI, 6'b010010 MFLO
dataA  input  WIDTH  multiplicand, sampled on MULTU accept
dataB  input  WIDTH  multiplier, sampled on MULTU accept
dataOut  output  WIDTH  registered HI or LO read result
out_valid  output  1  one-cycle pulse; dataOut valid for MFHI/MFLO
busy  output  1  high while a multiply is in flight (states RUN and DONE)
done  output  1  one-cycle pulse when HI/LO commit
hi  output  WIDTH  architectural HI register
lo  output  WIDTH  architectural LO register
bad_op  output  1  one-cycle pulse; accepted request had an unsupported funct

Behaviour:
- Accept condition: req_valid && req_ready. req_ready = (state==IDLE) && !reset.
- Reset (synchronous, any state): state<=IDLE; hi, lo, dataOut, product, multiplicand, multiplier and counter <= 0; out_valid, done, bad_op <= 0. In-flight multiply is discarded and HI/LO are not updated.
- States: IDLE, RUN, DONE.
- IDLE, MULTU accepted:
  - product<=0; mcnd<={WIDTH'b0,dataA} (2*WIDTH bits); mpr<=dataB; cnt<=0.
  - -> RUN.
- IDLE, MFHI accepted: dataOut<=hi; out_valid pulses next cycle; stay IDLE.
- IDLE, MFLO accepted: dataOut<=lo; out_valid pulses next cycle; stay IDLE.
- IDLE, other funct accepted: no state change; bad_op pulses next cycle; dataOut holds.
- RUN, each cycle:
  - if mpr[0], product<=product+mcnd (mod 2**(2*WIDTH)).
  - mcnd<=mcnd<<1; mpr<=mpr>>1; cnt<=cnt+1.
  - When cnt==WIDTH-1, this is the final iteration -> DONE.
- DONE, one cycle: {hi,lo}<=product; done=1 this cycle; -> IDLE.
- Latency: MULTU accepted at edge E; RUN occupies WIDTH cycles; done is high in the cycle after edge E+WIDTH. HI/LO show the new value after edge E+WIDTH+1. Next request can be accepted at edge E+WIDTH+2.
- No bypass: MFHI/MFLO cannot be accepted while busy (req_ready=0). After done, a read returns the new product.
- Operands are sampled only at accept. dataA/dataB changes during RUN are ignored.
- Unsigned only. 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE_00000001 with no overflow flag.
- Outputs hi/lo/dataOut hold value until the next commit, read, or reset.

Optional Feature:
MUL_EARLY_EXIT_EN
- Defined: in RUN, the transition to DONE also occurs when the next mpr value (mpr>>1) is 0, after the current iteration's add. Latency becomes max(1, index of highest set bit of dataB + 1) RUN cycles. dataB=0 gives 1 RUN cycle. Results are identical to the base mode.
- Undefined: always exactly WIDTH RUN cycles, independent of operands.

Test Plan:
1. Reset, then MULTU dataA=6, dataB=7 -> busy for WIDTH+1 cycles; done pulses once; hi=0, lo=42. Then MFLO -> out_valid with dataOut=42.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MFHI -> dataOut=0xFFFFFFFE.
3. Hold req_valid with MFHI during RUN -> req_ready=0 throughout, so no out_valid until after done. The read then returns the new hi.
4. Assert reset at RUN cycle 10 of MULTU 3x5 -> next cycle IDLE, hi=lo=0, no done pulse. A following MULTU 3x5 gives lo=15.
5. Accept Signal=6'b100000 in IDLE -> bad_op pulses once; hi/lo/dataOut unchanged; req_ready stays 1.
6. With MUL_EARLY_EXIT_EN: MULTU 9 x 4 -> 3 RUN cycles, lo=36. MULTU 9 x 0 -> 1 RUN cycle, lo=0. Without the macro, both take 32 RUN cycles.
